// File: rtl/dds_cmd_ctrl.sv
// Two-channel DDS command controller: validates 12-byte frames, updates per-channel
// shadow/active tone registers, and answers each frame with a 2-byte UART acknowledge.
module dds_ch #(
  parameter logic [31:0] DEF_FREQ = 32'h0000_0000,
  parameter logic [11:0] DEF_AMP  = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        commit,
  input  logic        load_def,
  input  logic [61:0] cfg,
  output logic [61:0] act
);
  // {freq, phase, amp, wave}
  localparam logic [61:0] DEF = {DEF_FREQ, 16'h0000, DEF_AMP, 2'b00};

  logic [61:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= DEF;
      act    <= DEF;
    end else if (load_def) begin
      shadow <= DEF;
      act    <= DEF;
    end else begin
      if (wr)     shadow <= cfg;
      if (commit) act    <= shadow;
    end
  end
endmodule

module dds_cmd_ctrl #(
  parameter logic [31:0] DEF_FREQ = 32'h0000_0000,
  parameter logic [11:0] DEF_AMP  = 12'hFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        recv_done,
  input  logic [7:0]  rev_data0,
  input  logic [7:0]  rev_data1,
  input  logic [7:0]  rev_data2,
  input  logic [7:0]  rev_data3,
  input  logic [7:0]  rev_data4,
  input  logic [7:0]  rev_data5,
  input  logic [7:0]  rev_data6,
  input  logic [7:0]  rev_data7,
  input  logic [7:0]  rev_data8,
  input  logic [7:0]  rev_data9,
  input  logic [7:0]  rev_data10,
  input  logic [7:0]  rev_data11,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [31:0] ch0_freq,
  output logic [31:0] ch1_freq,
  output logic [15:0] ch0_phase,
  output logic [15:0] ch1_phase,
  output logic [11:0] ch0_amp,
  output logic [11:0] ch1_amp,
  output logic [1:0]  ch0_wave,
  output logic [1:0]  ch1_wave,
  output logic [1:0]  dds_update,
  output logic        busy,
  output logic        frame_drop,
  output logic [7:0]  err_cnt
);
  localparam int NUM_CH = 2;

  typedef enum logic [2:0] {IDLE, CHECK, EXEC, TX_HDR, TX_HDR_W, TX_ST, TX_ST_W} state_t;
  typedef struct packed {
    logic [31:0] freq;
    logic [15:0] phase;
    logic [11:0] amp;
    logic [1:0]  wave;
  } ch_cfg_t;

  state_t state, nxt;
  logic [11:0][7:0] rx, frame;
  logic [7:0]  status, status_c, csum, cmd, chn;
  logic [NUM_CH-1:0] sel, wr, commit, load_def;
  logic [NUM_CH-1:0][61:0] act;
  logic armed, busy_seen, exec_ok;
  ch_cfg_t cfg, a0, a1;

  assign rx = {rev_data11, rev_data10, rev_data9, rev_data8, rev_data7, rev_data6,
               rev_data5, rev_data4, rev_data3, rev_data2, rev_data1, rev_data0};
  assign cmd  = frame[0];
  assign chn  = frame[1];
  assign busy = (state != IDLE);

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 11; i++) csum = csum ^ frame[i];
  end

  always_comb begin
    status_c = 8'h00;
    if (csum != frame[11])                         status_c = 8'h01;
    else if (cmd == 8'h00 || cmd > 8'h03)          status_c = 8'h02;
    else if (cmd == 8'h01 ? (chn > 8'h01)
                          : !(chn <= 8'h01 || chn == 8'hFF)) status_c = 8'h03;
  end

  always_comb begin
    sel = 2'b00;
    if (chn == 8'h00)      sel = 2'b01;
    else if (chn == 8'h01) sel = 2'b10;
    else if (chn == 8'hFF) sel = 2'b11;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= nxt;
  end

  // tx_en is combinational so it can only ever be high inside TX_HDR/TX_ST.
  always_comb begin
    nxt   = state;
    tx_en = 1'b0;
    case (state)
      IDLE:     if (recv_done && armed) nxt = CHECK;
      CHECK:    nxt = EXEC;
      EXEC:     nxt = TX_HDR;
      TX_HDR:   if (!tx_busy) begin tx_en = 1'b1; nxt = TX_HDR_W; end
      TX_HDR_W: if (busy_seen && !tx_busy) nxt = TX_ST;
      TX_ST:    if (!tx_busy) begin tx_en = 1'b1; nxt = TX_ST_W; end
      TX_ST_W:  if (busy_seen && !tx_busy) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  assign exec_ok  = (state == EXEC) && (status == 8'h00);
  assign wr       = (exec_ok && cmd == 8'h01) ? sel : 2'b00;
  assign commit   = (exec_ok && cmd == 8'h02) ? sel : 2'b00;
  assign load_def = (exec_ok && cmd == 8'h03) ? sel : 2'b00;
  assign cfg      = {frame[2], frame[3], frame[4], frame[5], frame[6], frame[7],
                     frame[8][3:0], frame[9], frame[10][1:0]};

  // armed blocks a recv_done on the first edge after reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed      <= 1'b0;
      frame      <= '0;
      status     <= 8'h00;
      busy_seen  <= 1'b0;
      tx_data    <= 8'h00;
      dds_update <= 2'b00;
      frame_drop <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      armed      <= 1'b1;
      frame_drop <= recv_done && (state != IDLE);
      dds_update <= commit | load_def;
      busy_seen  <= (state == TX_HDR_W || state == TX_ST_W) && (nxt == state)
                    && (busy_seen || tx_busy);
      if (state == IDLE && recv_done && armed) frame <= rx;
      if (state == CHECK) status <= status_c;
      if (state == EXEC && status != 8'h00 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
      if (state == EXEC) tx_data <= 8'hA5;
      else if (state == TX_HDR_W && nxt == TX_ST) tx_data <= status;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dds_ch #(.DEF_FREQ(DEF_FREQ), .DEF_AMP(DEF_AMP)) u_ch (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .wr       (wr[c]),
      .commit   (commit[c]),
      .load_def (load_def[c]),
      .cfg      (cfg),
      .act      (act[c])
    );
  end

  assign a0 = act[0];
  assign a1 = act[1];
  assign ch0_freq  = a0.freq;
  assign ch0_phase = a0.phase;
  assign ch0_amp   = a0.amp;
  assign ch0_wave  = a0.wave;
  assign ch1_freq  = a1.freq;
  assign ch1_phase = a1.phase;
  assign ch1_amp   = a1.amp;
  assign ch1_wave  = a1.wave;
endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// Directed bench for dds_cmd_ctrl with a simple UART busy model capturing ack bytes.
module tb_dds_cmd_ctrl;
  typedef logic [11:0][7:0] frame_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        recv_done = 1'b0;
  frame_t      fr = '0;
  logic        tx_busy, hold_busy = 1'b0;
  logic        tx_en, busy, frame_drop;
  logic [7:0]  tx_data, err_cnt;
  logic [31:0] ch0_freq, ch1_freq;
  logic [15:0] ch0_phase, ch1_phase;
  logic [11:0] ch0_amp, ch1_amp;
  logic [1:0]  ch0_wave, ch1_wave, dds_update;

  int n_chk = 0, n_err = 0, fd_cnt = 0, busy_cnt = 0;
  logic [7:0] q[$];

  always #5 sys_clk = ~sys_clk;

  dds_cmd_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .recv_done(recv_done),
    .rev_data0(fr[0]), .rev_data1(fr[1]), .rev_data2(fr[2]), .rev_data3(fr[3]),
    .rev_data4(fr[4]), .rev_data5(fr[5]), .rev_data6(fr[6]), .rev_data7(fr[7]),
    .rev_data8(fr[8]), .rev_data9(fr[9]), .rev_data10(fr[10]), .rev_data11(fr[11]),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .ch0_freq(ch0_freq), .ch1_freq(ch1_freq), .ch0_phase(ch0_phase), .ch1_phase(ch1_phase),
    .ch0_amp(ch0_amp), .ch1_amp(ch1_amp), .ch0_wave(ch0_wave), .ch1_wave(ch1_wave),
    .dds_update(dds_update), .busy(busy), .frame_drop(frame_drop), .err_cnt(err_cnt)
  );

  // UART model: accepts a byte on tx_en, then stays busy for 3 cycles.
  assign tx_busy = hold_busy || (busy_cnt != 0);
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) busy_cnt <= 0;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_en) begin
      q.push_back(tx_data);
      busy_cnt <= 3;
    end
  end

  always @(posedge sys_clk) if (frame_drop) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] cmd, input logic [7:0] ch,
                                input logic [31:0] frq, input logic [15:0] ph,
                                input logic [11:0] amp, input logic [1:0] wv);
    frame_t f;
    f[0] = cmd; f[1] = ch;
    f[2] = frq[31:24]; f[3] = frq[23:16]; f[4] = frq[15:8]; f[5] = frq[7:0];
    f[6] = ph[15:8]; f[7] = ph[7:0];
    f[8] = {4'h0, amp[11:8]}; f[9] = amp[7:0];
    f[10] = {6'b0, wv};
    f[11] = 8'h00;
    for (int i = 0; i < 11; i++) f[11] = f[11] ^ f[i];
    return f;
  endfunction

  task automatic cyc();
    @(posedge sys_clk); #1;
  endtask

  task automatic send_raw(input frame_t f);
    fr = f; recv_done = 1'b1;
    cyc();
    recv_done = 1'b0;
  endtask

  // dds_update must appear exactly 3 cycles after the recv_done cycle, for one cycle.
  task automatic send(input frame_t f, input logic [1:0] exp_upd);
    send_raw(f);
    cyc(); chk("upd_early", dds_update, 2'b00);
    cyc(); chk("upd", dds_update, exp_upd);
    cyc(); chk("upd_late", dds_update, 2'b00);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin cyc(); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic ack(input logic [7:0] st);
    wait_idle();
    chk("ack_len", q.size(), 2);
    chk("ack_hdr", (q.size() > 0) ? q[0] : 8'h00, 8'hA5);
    chk("ack_st", (q.size() > 1) ? q[1] : 8'hEE, st);
    q.delete();
  endtask

  frame_t f;
  int n;

  initial begin
    cyc(); cyc();
    chk("rst_ch0_freq", ch0_freq, 32'h0);
    chk("rst_ch0_amp", ch0_amp, 12'hFFF);
    chk("rst_ch1_amp", ch1_amp, 12'hFFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx", {tx_en, tx_data}, 9'h0);
    chk("rst_err", err_cnt, 8'h0);
    // recv_done on the first edge after release is ignored
    fr = mk(8'h03, 8'h00, 32'h0, 16'h0, 12'h0, 2'd0);
    recv_done = 1'b1; sys_rst_n = 1'b1;
    cyc(); recv_done = 1'b0;
    chk("first_edge_ignored", busy, 1'b0);
    cyc(); cyc();

    // write shadow ch0: no visible change
    send(mk(8'h01, 8'h00, 32'h12345678, 16'h0400, 12'h800, 2'd2), 2'b00);
    chk("wr_no_change", ch0_freq, 32'h0);
    ack(8'h00);

    // commit both channels
    send(mk(8'h02, 8'hFF, 32'h0, 16'h0, 12'h0, 2'd0), 2'b11);
    chk("c0_freq", ch0_freq, 32'h12345678);
    chk("c0_misc", {ch0_phase, ch0_amp, ch0_wave}, {16'h0400, 12'h800, 2'd2});
    chk("c1_vals", {ch1_freq, ch1_phase, ch1_amp, ch1_wave}, {32'h0, 16'h0, 12'hFFF, 2'd0});
    ack(8'h00);

    // corrupted checksum
    f = mk(8'h03, 8'hFF, 32'h0, 16'h0, 12'h0, 2'd0);
    f[11] = f[11] ^ 8'h40;
    send(f, 2'b00);
    chk("bad_cs_keep", ch0_freq, 32'h12345678);
    ack(8'h01);
    chk("err1", err_cnt, 8'd1);

    send(mk(8'h07, 8'h00, 32'h0, 16'h0, 12'h0, 2'd0), 2'b00);
    ack(8'h02);
    send(mk(8'h01, 8'hFF, 32'h0, 16'h0, 12'h0, 2'd0), 2'b00);
    ack(8'h03);
    chk("err3", err_cnt, 8'd3);
    send(mk(8'h02, 8'h02, 32'h0, 16'h0, 12'h0, 2'd0), 2'b00);
    ack(8'h03);

    // overlapping frame while UART is stuck busy
    n = fd_cnt;
    hold_busy = 1'b1;
    send(mk(8'h02, 8'h00, 32'h0, 16'h0, 12'h0, 2'd0), 2'b01);
    send_raw(mk(8'h03, 8'h00, 32'h0, 16'h0, 12'h0, 2'd0));
    chk("drop_pulse", frame_drop, 1'b1);
    cyc();
    chk("drop_one_cycle", frame_drop, 1'b0);
    repeat (5) cyc();
    chk("tx_en_wait", tx_en, 1'b0);
    chk("tx_none_yet", q.size(), 0);
    hold_busy = 1'b0;
    ack(8'h00);
    chk("drop_cnt", fd_cnt - n, 1);
    chk("drop_no_effect", ch0_freq, 32'h12345678);

    // cmd 0x03 restores defaults in shadow and active
    send(mk(8'h01, 8'h01, 32'hAABBCCDD, 16'h1234, 12'h123, 2'd1), 2'b00); ack(8'h00);
    send(mk(8'h02, 8'h01, 32'h0, 16'h0, 12'h0, 2'd0), 2'b10); ack(8'h00);
    chk("c1_commit", {ch1_freq, ch1_phase, ch1_amp, ch1_wave},
        {32'hAABBCCDD, 16'h1234, 12'h123, 2'd1});
    send(mk(8'h03, 8'h01, 32'h0, 16'h0, 12'h0, 2'd0), 2'b10); ack(8'h00);
    chk("c1_def", {ch1_freq, ch1_amp}, {32'h0, 12'hFFF});
    chk("c0_untouched", ch0_freq, 32'h12345678);
    send(mk(8'h02, 8'h01, 32'h0, 16'h0, 12'h0, 2'd0), 2'b10); ack(8'h00);
    chk("c1_shadow_def", ch1_freq, 32'h0);

    // saturation
    f = mk(8'h09, 8'h00, 32'h0, 16'h0, 12'h0, 2'd0);
    for (int i = 0; i < 300; i++) begin
      send_raw(f);
      wait_idle();
      q.delete();
    end
    chk("err_sat", err_cnt, 8'hFF);

    // reset during TX_ST_W
    send_raw(mk(8'h01, 8'h00, 32'hCAFEF00D, 16'h0, 12'h0, 2'd0));
    n = 0;
    while (q.size() < 2 && n < 200) begin cyc(); n++; end
    chk("second_byte_seen", q.size(), 2);
    cyc();
    chk("in_tx_st_w", busy, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ch0", {ch0_freq, ch0_phase, ch0_amp, ch0_wave}, {32'h0, 16'h0, 12'hFFF, 2'd0});
    chk("mid_rst_out", {tx_en, tx_data, dds_update, frame_drop, err_cnt}, 20'h0);
    cyc(); cyc();
    sys_rst_n = 1'b1;
    q.delete();
    cyc(); cyc();
    chk("no_resume", q.size(), 0);
    send(mk(8'h01, 8'h00, 32'h0BADBEEF, 16'h0, 12'h0, 2'd3), 2'b00); ack(8'h00);
    send(mk(8'h02, 8'h00, 32'h0, 16'h0, 12'h0, 2'd0), 2'b01); ack(8'h00);
    chk("post_rst_freq", {ch0_freq, ch0_wave}, {32'h0BADBEEF, 2'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dds_cmd_ctrl.md
DDS_CMD_CTRL -- requirements
Module: dds_cmd_ctrl

Interface
REQ-001 SHALL have parameter DEF_FREQ, 32'h0000_0000, reset/default frequency word for both channels.
REQ-002 SHALL have parameter DEF_AMP, 12'hFFF, reset/default amplitude for both channels.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous reset, active-low.
- recv_done  in  1  one-cycle pulse: validated frame payload present on rev_data0..11.
- rev_data0..rev_data11  in  8 each  frame payload, stable while recv_done is high.
- tx_busy  in  1  UART transmitter busy.
- tx_en  out  1  one-cycle transmit request.
- tx_data  out  8  byte to transmit; valid while tx_en is high.
- ch0_freq / ch1_freq  out  32  active frequency words.
- ch0_phase / ch1_phase  out  16  active phase offsets.
- ch0_amp / ch1_amp  out  12  active amplitudes.
- ch0_wave / ch1_wave  out  2  active waveform selects.
- dds_update  out  2  one-cycle pulse per channel when its active registers change.
- busy  out  1  high in every state except IDLE.
- frame_drop  out  1  one-cycle pulse when a frame is ignored.
- err_cnt  out  8  saturating count of NAKed frames.

Function
REQ-004 SHALL use this frame map: byte0 cmd; byte1 channel; bytes2..5 freq, MSB first; bytes6..7 phase, MSB first; bytes8..9 amp (bits 11:0 of {byte8,byte9}); byte10[1:0] wave; byte11 checksum.
REQ-005 SHALL treat the checksum as valid when byte11 equals the XOR of byte0 through byte10.
REQ-006 SHALL implement FSM states IDLE, CHECK, EXEC, TX_HDR, TX_HDR_W, TX_ST, TX_ST_W, with reset state IDLE.
REQ-007 SHALL, in IDLE on recv_done, latch all 12 payload bytes into an internal frame buffer and go to CHECK.
REQ-008 SHALL, in CHECK, compute the status code using this priority and then go to EXEC:
- bad checksum: 0x01
- cmd not in {0x01, 0x02, 0x03}: 0x02
- bad channel: 0x03
- otherwise: 0x00
REQ-009 SHALL define the legal channel values as: cmd 0x01 accepts 0 or 1 only; cmd 0x02 and 0x03 accept 0, 1, or 0xFF (0xFF means both channels).
REQ-010 SHALL, in EXEC with status 0x00, act on the selected channel(s) according to cmd:
- cmd 0x01: write freq, phase, amp and wave into the channel's shadow registers; active outputs unchanged; no dds_update.
- cmd 0x02: copy shadow registers to active outputs and pulse dds_update for each selected channel in the same cycle.
- cmd 0x03: load defaults (DEF_FREQ, phase 0, DEF_AMP, wave 0) into both shadow and active registers and pulse dds_update for each selected channel.
REQ-011 SHALL, in EXEC with nonzero status, change no shadow or active register and increment err_cnt, saturating at 0xFF.
REQ-012 SHALL produce active-register changes and dds_update exactly 3 cycles after the recv_done cycle (IDLE→CHECK→EXEC, registered in EXEC).
REQ-013 SHALL, after EXEC, send a 2-byte acknowledge: 0xA5, then the status code.
REQ-014 SHALL drive the acknowledge handshake as follows:
- In TX_HDR and TX_ST, pulse tx_en for one cycle with tx_data, only when tx_busy is 0; otherwise wait.
- Then wait in the matching _W state for tx_busy to rise and subsequently fall.
- After TX_ST_W completes, return to IDLE.
REQ-015 SHALL hold tx_data stable from its tx_en pulse until the following _W state exits.
REQ-016 SHALL, on recv_done while not in IDLE, pulse frame_drop for one cycle, leave the frame buffer untouched, and continue the current transaction.
REQ-017 SHALL accept a recv_done in the same cycle the FSM returns to IDLE on the next cycle only; that pulse is dropped, per REQ-016.
REQ-018 SHALL keep dds_update at 0 outside EXEC and tx_en at 0 outside TX_HDR and TX_ST.

Reset
REQ-019 SHALL, on sys_rst_n low, immediately and asynchronously:
- enter IDLE;
- set tx_en=0, tx_data=0, dds_update=0, busy=0, frame_drop=0, err_cnt=0;
- set active and shadow freq=DEF_FREQ, phase=0, amp=DEF_AMP, wave=0 on both channels.
REQ-020 SHALL abort any in-progress transaction or acknowledge when reset asserts mid-operation, with no resumption after release.
REQ-021 SHALL ignore recv_done on the first clock edge after sys_rst_n deasserts.

Verification
REQ-022 SHALL pass: cmd 0x01, ch 0, freq 0x12345678, phase 0x0400, amp 0x800, wave 2, correct checksum → outputs unchanged, no dds_update, TX sends A5 then 00.
REQ-023 SHALL pass: the REQ-022 frame followed by cmd 0x02, ch 0xFF → ch0_freq=0x12345678, ch1 outputs unchanged values rewritten, dds_update=2'b11 for one cycle exactly 3 cycles after recv_done.
REQ-024 SHALL pass: frame with byte11 XOR-corrupted → no register change, err_cnt 0→1, TX sends A5 then 01.
REQ-025 SHALL pass: cmd 0x07 → TX sends A5 then 02; cmd 0x01 with ch 0xFF → TX sends A5 then 03; 300 bad frames → err_cnt stays at 0xFF.
REQ-026 SHALL pass: second recv_done while tx_busy is held high → frame_drop pulses once, only the first frame takes effect, tx_en waits until tx_busy falls.
REQ-027 SHALL pass: reset asserted in TX_ST_W → all outputs at reset values, after release next valid frame handled normally.
